// File: rtl/priority_arbiter_pkg.sv
// Shared definitions for the priority arbiter: mode encodings and FSM state type.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package priority_arbiter_pkg;

  // Arbitration mode, as driven on the mode input
  localparam logic MODE_FIXED = 1'b0;  // highest set index wins
  localparam logic MODE_RR    = 1'b1;  // first set index at or above ptr, wrapping

  // Arbiter FSM states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/priority_search.sv
// Combinational winner search over N request lines, fixed-priority or round-robin.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is loaded.
//
// Ports:
//   D       in  N  request lines
//   ptr     in  W  round-robin start index (must be < N)
//   mode    in  1  MODE_FIXED / MODE_RR
//   any     out 1  at least one request line set
//   win_idx out W  winning index (meaningful only when any=1)
module priority_search
  import priority_arbiter_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] D,
  input  logic [W-1:0] ptr,
  input  logic         mode,
  output logic         any,
  output logic [W-1:0] win_idx
);

  localparam logic [W:0] N_W = (W+1)'(N);

  logic [2*N-1:0] dd;
  logic [N-1:0]   rot;
  logic [W-1:0]   fix_idx;
  logic [W-1:0]   rr_off;
  logic [W:0]     rr_sum;

  always_comb begin
    // Rotate right by ptr so the round-robin start position lands on bit 0.
    dd  = {D, D} >> ptr;
    rot = dd[N-1:0];

    // Fixed priority: walk upward; a higher set index overwrites a lower one.
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (D[i]) fix_idx = W'(i);
    end

    // Round-robin: lowest set bit of the rotated vector, found by walking downward.
    rr_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) rr_off = W'(i);
    end

    // Undo the rotation: (rr_off + ptr) mod N; both operands are < N so one subtract suffices.
    rr_sum = {1'b0, rr_off} + {1'b0, ptr};
    if (rr_sum >= N_W) rr_sum = rr_sum - N_W;

    any     = |D;
    win_idx = (mode == MODE_FIXED) ? fix_idx : rr_sum[W-1:0];
  end

endmodule

// File: rtl/priority_arbiter.sv
// Registered N-input priority / round-robin arbiter with a sticky grant held until ack.
// Latency: request seen at edge k gives V=1 after edge k; back-to-back grants on ack, no bubble.
// Backpressure: grant (V, idx, grant) holds while ack=0; ack with V=0 is ignored.
//
// Ports:
//   clock   in  1  rising-edge clock
//   reset_b in  1  asynchronous active-low reset
//   mode    in  1  0 = fixed priority, 1 = round-robin (sampled only when a winner is chosen)
//   D       in  N  level-sensitive request lines
//   ack     in  1  consumer accepts the current grant
//   V       out 1  grant valid
//   idx     out W  granted index, 0 when V=0
//   grant   out N  one-hot of idx when V=1, else 0
module priority_arbiter
  import priority_arbiter_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clock,
  input  logic         reset_b,
  input  logic         mode,
  input  logic [N-1:0] D,
  input  logic         ack,
  output logic         V,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant
);

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  state_e       state_q;
  logic         v_q;
  logic [W-1:0] idx_q;
  logic [N-1:0] grant_q;
  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  logic         accept;
  logic [W-1:0] srch_ptr;
  logic         srch_any;
  logic [W-1:0] srch_idx;
  logic [N-1:0] srch_onehot;

  assign accept = (state_q == ST_GRANT) && ack;

  // Pointer moves just past the line being released.
  assign ptr_d = (idx_q == LAST_IDX) ? '0 : idx_q + W'(1);

  // On an accept the new winner is searched from the updated pointer in the same edge.
  assign srch_ptr    = accept ? ptr_d : ptr_q;
  assign srch_onehot = N'(1) << srch_idx;

  priority_search #(
    .N(N)
  ) u_search (
    .D      (D),
    .ptr    (srch_ptr),
    .mode   (mode),
    .any    (srch_any),
    .win_idx(srch_idx)
  );

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= ST_IDLE;
      v_q     <= 1'b0;
      idx_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else if (state_q == ST_IDLE) begin
      if (srch_any) begin
        state_q <= ST_GRANT;
        v_q     <= 1'b1;
        idx_q   <= srch_idx;
        grant_q <= srch_onehot;
      end
    end else if (ack) begin
      // ST_GRANT with ack: release, then immediately re-arbitrate on the current D.
      ptr_q <= ptr_d;
      if (srch_any) begin
        v_q     <= 1'b1;
        idx_q   <= srch_idx;
        grant_q <= srch_onehot;
      end else begin
        state_q <= ST_IDLE;
        v_q     <= 1'b0;
        idx_q   <= '0;
        grant_q <= '0;
      end
    end
    // ST_GRANT without ack: everything holds, even if D[idx] has dropped.
  end

  assign V     = v_q;
  assign idx   = idx_q;
  assign grant = grant_q;

endmodule

// File: tb/tb_priority_arbiter.sv
module tb_priority_arbiter;
  import priority_arbiter_pkg::*;

  localparam int N = 4;
  localparam int W = 2;

  logic         clock = 1'b0;
  logic         reset_b;
  logic         mode;
  logic [N-1:0] D;
  logic         ack;
  logic         V;
  logic [W-1:0] idx;
  logic [N-1:0] grant;

  typedef struct packed {
    logic         v;
    logic [W-1:0] idx;
    logic [N-1:0] grant;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   mon_cyc = 0;
  bit   started = 1'b0;

  // Reference model state: is a grant held, which line, round-robin start.
  int m_v   = 0;
  int m_idx = 0;
  int m_ptr = 0;

  priority_arbiter #(.N(N)) dut (
    .clock  (clock),
    .reset_b(reset_b),
    .mode   (mode),
    .D      (D),
    .ack    (ack),
    .V      (V),
    .idx    (idx),
    .grant  (grant)
  );

  always #5 clock = ~clock;

  function automatic int pick(input logic [N-1:0] d, input logic m, input int p);
    if (m == MODE_FIXED) begin
      for (int i = N - 1; i >= 0; i--) if (d[i]) return i;
    end else begin
      for (int k = 0; k < N; k++) if (d[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.v     = (m_v != 0);
    e.idx   = m_v != 0 ? m_idx[W-1:0] : '0;
    e.grant = '0;
    if (m_v != 0) e.grant[m_idx] = 1'b1;
    return e;
  endfunction

  task automatic model_reset();
    m_v = 0; m_idx = 0; m_ptr = 0;
  endtask

  // What one clock edge does, given the inputs present at that edge.
  task automatic model_edge(input logic r, input logic m, input logic [N-1:0] d, input logic a);
    if (!r) begin
      model_reset();
    end else begin
      if (m_v != 0 && a) begin
        m_ptr = (m_idx + 1) % N;
        m_v   = 0;
        m_idx = 0;
      end
      if (m_v == 0 && d != '0) begin
        m_idx = pick(d, m, m_ptr);
        m_v   = 1;
      end
    end
  endtask

  // Drive one cycle's inputs on the falling edge and queue what the next rising edge must show.
  task automatic cycle(input logic r, input logic m, input logic [N-1:0] d, input logic a);
    @(negedge clock);
    reset_b = r; mode = m; D = d; ack = a;
    model_edge(r, m, d, a);
    exp_q.push_back(model_out());
    started = 1'b1;
  endtask

  task automatic check_now(input string name, input exp_t e);
    n_cmp++;
    if (V !== e.v || idx !== e.idx || grant !== e.grant) begin
      n_err++;
      $display("FAIL %s: got V=%0b idx=%0d grant=%b, expected V=%0b idx=%0d grant=%b",
               name, V, idx, grant, e.v, e.idx, e.grant);
    end
  endtask

  // Monitor: one expectation per rising edge, sampled 1 time unit after it.
  initial begin
    wait (started);
    forever begin
      @(posedge clock);
      #1;
      mon_cyc++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard_underflow cycle %0d: DUT V=%0b idx=%0d with no expectation queued",
                 mon_cyc, V, idx);
      end else begin
        check_now($sformatf("cycle %0d", mon_cyc), exp_q.pop_front());
      end
    end
  end

  initial begin
    exp_t zero;
    zero = '0;

    // 1: reset held with requests present, then release.
    reset_b = 1'b0; mode = MODE_FIXED; D = 4'b1010; ack = 1'b0;
    #2;
    check_now("reset_state", zero);
    repeat (3) cycle(1'b0, MODE_FIXED, 4'b1010, 1'b0);
    cycle(1'b1, MODE_FIXED, 4'b1010, 1'b0);            // idx 3

    // 2: fixed priority, ack every cycle, then drain.
    repeat (4) cycle(1'b1, MODE_FIXED, 4'b1010, 1'b1); // idx 3, no bubble
    cycle(1'b1, MODE_FIXED, 4'b0000, 1'b1);            // V=0
    cycle(1'b1, MODE_FIXED, 4'b0000, 1'b0);

    // 3: round-robin from ptr=0 on 1010 -> 1, 3, 1.
    cycle(1'b1, MODE_RR, 4'b1010, 1'b0);
    cycle(1'b1, MODE_RR, 4'b1010, 1'b1);
    cycle(1'b1, MODE_RR, 4'b1010, 1'b1);
    cycle(1'b1, MODE_RR, 4'b0000, 1'b1);

    // 4: sticky grant on line 2 survives the request dropping.
    cycle(1'b1, MODE_FIXED, 4'b0100, 1'b0);
    repeat (5) cycle(1'b1, MODE_RR, 4'b0000, 1'b0);
    cycle(1'b1, MODE_FIXED, 4'b0000, 1'b1);
    cycle(1'b1, MODE_FIXED, 4'b0000, 1'b1);            // ack with V=0 ignored

    // 5: round-robin, all lines requesting, from a fresh ptr=0.
    cycle(1'b0, MODE_RR, 4'b0000, 1'b0);
    cycle(1'b1, MODE_RR, 4'b1111, 1'b0);
    repeat (8) cycle(1'b1, MODE_RR, 4'b1111, 1'b1);

    // 6: async reset mid-cycle during a held grant.
    cycle(1'b1, MODE_RR, 4'b1111, 1'b0);
    @(posedge clock);
    #3;
    reset_b = 1'b0;
    model_reset();
    #1;
    check_now("async_reset_drop", zero);
    cycle(1'b0, MODE_RR, 4'b0011, 1'b0);
    cycle(1'b1, MODE_RR, 4'b0011, 1'b0);               // ptr back to 0 -> idx 0
    cycle(1'b1, MODE_RR, 4'b0011, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 39) != 0, 1'($urandom), 4'($urandom),
            $urandom_range(0, 2) != 0);
    end

    @(posedge clock);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
